// File: rtl/irrigation_timer_bcd.sv
// Parametrised BCD run-time timer (MM:SS / HH:MM:SS) with preset load, up/down
// counting, pause/resume, terminal detection and a multiplexed 7-segment scan.
module irrigation_timer_bcd #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000000,
    parameter int SCAN_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   preset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    input  logic                  dir,
    output logic [4*DIGITS-1:0]   count,
    output logic                  running,
    output logic                  expired,
    output logic                  done,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     dig_sel
);

    localparam int W  = 4 * DIGITS;
    localparam int PW = $clog2(PRESCALE);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(DIGITS);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_EXPIRED} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    count_q, count_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            dir_q, dir_d;
    logic            done_q, done_d;
    logic [SW-1:0]   scan_cnt_q, scan_cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [DIGITS-1:0] dig_sel_q, dig_sel_d;
    logic [6:0]      seg_q, seg_d;
    logic [W-1:0]    step_val;
    logic [3:0]      cur_dig;

    // Seconds/minutes digits alternate mod 10 / mod 6; the top digit is always mod 10.
    function automatic logic [3:0] dig_max(input int i);
        return ((i % 2 == 0) || (i == DIGITS - 1)) ? 4'd9 : 4'd5;
    endfunction

    function automatic logic [W-1:0] bcd_step(input logic [W-1:0] v, input logic down);
        logic [W-1:0] r;
        logic         c;
        logic [3:0]   d;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d = v[4*i +: 4];
            if (c) begin
                if (down) begin
                    if (d == 4'd0) r[4*i +: 4] = dig_max(i);
                    else begin
                        r[4*i +: 4] = d - 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (d >= dig_max(i)) r[4*i +: 4] = 4'd0;
                    else begin
                        r[4*i +: 4] = d + 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] clamp(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > dig_max(i)) r[4*i +: 4] = dig_max(i);
        end
        return r;
    endfunction

    function automatic logic is_max(input logic [W-1:0] v);
        logic m;
        m = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] != dig_max(i)) m = 1'b0;
        end
        return m;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1111110;
            4'd1:    return 7'b0110000;
            4'd2:    return 7'b1101101;
            4'd3:    return 7'b1111001;
            4'd4:    return 7'b0110011;
            4'd5:    return 7'b1011011;
            4'd6:    return 7'b1011111;
            4'd7:    return 7'b1110000;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        presc_d  = presc_q;
        dir_d    = dir_q;
        done_d   = 1'b0;
        step_val = bcd_step(count_q, dir_q);
        if (clear) begin
            count_d = '0;
            presc_d = '0;
            state_d = S_IDLE;
        end else if (load) begin
            count_d = clamp(preset);
            presc_d = '0;
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (stop) begin
                        state_d = S_PAUSE;
                    end else if (presc_q == PW'(PRESCALE - 1)) begin
                        presc_d = '0;
                        count_d = step_val;
                        if (dir_q ? (step_val == '0) : is_max(step_val)) begin
                            state_d = S_EXPIRED;
                            done_d  = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                S_IDLE: begin
                    // A same-cycle stop outranks start, so start is dropped.
                    if (start && !stop) begin
                        dir_d   = dir;
                        presc_d = '0;
                        if (dir && count_q == '0) begin
                            state_d = S_EXPIRED;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_RUN;
                        end
                    end
                end
                S_PAUSE: begin
                    if (start && !stop) state_d = S_RUN;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        scan_cnt_d = scan_cnt_q + SW'(1);
        idx_d      = idx_q;
        if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            idx_d      = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
        cur_dig = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            dig_sel_d[i] = (idx_d == IW'(i));
            if (idx_d == IW'(i)) cur_dig = count_q[4*i +: 4];
        end
        seg_d = seg_decode(cur_dig);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            presc_q    <= '0;
            dir_q      <= 1'b0;
            done_q     <= 1'b0;
            scan_cnt_q <= '0;
            idx_q      <= '0;
            dig_sel_q  <= {{(DIGITS-1){1'b0}}, 1'b1};
            seg_q      <= 7'b1111110;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            presc_q    <= presc_d;
            dir_q      <= dir_d;
            done_q     <= done_d;
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            dig_sel_q  <= dig_sel_d;
            seg_q      <= seg_d;
        end
    end

    assign count   = count_q;
    assign running = (state_q == S_RUN);
    assign expired = (state_q == S_EXPIRED);
    assign done    = done_q;
    assign seg     = seg_q;
    assign dig_sel = dig_sel_q;

endmodule

// File: tb/tb_irrigation_timer_bcd.sv
// Bench for irrigation_timer_bcd (DIGITS=4, PRESCALE=4, SCAN_DIV=2): a seconds-based
// reference model plus vector table, directed corner sequences and random pulses.
module tb_irrigation_timer_bcd;
    localparam int DIGITS   = 4;
    localparam int PRESCALE = 4;
    localparam int SCAN_DIV = 2;
    localparam int MAXV     = 99 * 60 + 59;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        load = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0, dir = 1'b0;
    logic [15:0] preset = '0;
    logic [15:0] count;
    logic        running, expired, done;
    logic [6:0]  seg;
    logic [3:0]  dig_sel;

    irrigation_timer_bcd #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .preset(preset), .start(start),
        .stop(stop), .clear(clear), .dir(dir), .count(count), .running(running),
        .expired(expired), .done(done), .seg(seg), .dig_sel(dig_sel)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    typedef struct {
        logic l; logic [15:0] p; logic s; logic sp; logic c; logic d;
        logic [15:0] e_cnt; logic e_run; logic e_exp; logic e_done;
    } vec_t;
    vec_t vt [13];

    logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                 7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
    logic [3:0] scan_exp [8] = '{4'b0001, 4'b0010, 4'b0010, 4'b0100,
                                 4'b0100, 4'b1000, 4'b1000, 4'b0001};

    // Model keeps the count as total seconds; BCD is only produced for comparison.
    int          m_secs, m_phase, m_pre, m_cyc;
    logic        m_down, m_done;
    logic [15:0] m_prev;

    function automatic logic [15:0] to_bcd(input int v);
        int mm, ss;
        mm = v / 60;
        ss = v % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic int preset_secs(input logic [15:0] p);
        int d0, d1, d2, d3;
        d0 = (int'(p[3:0])   > 9) ? 9 : int'(p[3:0]);
        d1 = (int'(p[7:4])   > 5) ? 5 : int'(p[7:4]);
        d2 = (int'(p[11:8])  > 9) ? 9 : int'(p[11:8]);
        d3 = (int'(p[15:12]) > 9) ? 9 : int'(p[15:12]);
        return (d3 * 10 + d2) * 60 + d1 * 10 + d0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_secs = 0; m_phase = M_IDLE; m_pre = 0; m_cyc = 0;
            m_down = 1'b0; m_done = 1'b0; m_prev = '0;
        end else begin
            m_prev = to_bcd(m_secs);
            m_cyc++;
            m_done = 1'b0;
            if (clear) begin
                m_secs = 0; m_phase = M_IDLE;
            end else if (load) begin
                m_secs = preset_secs(preset); m_phase = M_IDLE;
            end else if (m_phase == M_RUN) begin
                if (stop) m_phase = M_PAUSE;
                else if (m_pre == PRESCALE - 1) begin
                    m_pre  = 0;
                    m_secs = m_down ? (m_secs + MAXV) % (MAXV + 1) : (m_secs + 1) % (MAXV + 1);
                    if (m_secs == (m_down ? 0 : MAXV)) begin
                        m_phase = M_EXP; m_done = 1'b1;
                    end
                end else m_pre++;
            end else if (start && !stop) begin
                if (m_phase == M_IDLE) begin
                    m_down = dir; m_pre = 0;
                    if (dir && m_secs == 0) begin
                        m_phase = M_EXP; m_done = 1'b1;
                    end else m_phase = M_RUN;
                end else if (m_phase == M_PAUSE) m_phase = M_RUN;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [15:0] cur;
        int          idx;
        cur = to_bcd(m_secs);
        idx = (m_cyc / SCAN_DIV) % DIGITS;
        chk("m_count", count, cur);
        chk("m_running", running, m_phase == M_RUN);
        chk("m_expired", expired, m_phase == M_EXP);
        chk("m_done", done, m_done);
        chk("m_dig_sel", dig_sel, 4'b0001 << idx);
        checks++;
        if (seg !== seg_tab[cur[4*idx +: 4]] && seg !== seg_tab[m_prev[4*idx +: 4]]) begin
            failures++;
            $display("FAIL m_seg actual=%b required=%b at %0t", seg, seg_tab[cur[4*idx +: 4]], $time);
        end
    endtask

    task automatic step(input logic l, input logic [15:0] p, input logic s,
                        input logic sp, input logic c, input logic d);
        load = l; preset = p; start = s; stop = sp; clear = c; dir = d;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
        check_model();
    endtask

    task automatic idle(input logic d);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, d);
    endtask

    initial begin
        vt[0]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 16'h0A7F, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0959, 1'b0, 1'b0, 1'b0};
        vt[2]  = '{1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
        vt[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1};
        vt[4]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0};
        vt[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0};
        vt[6]  = '{1'b1, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0005, 1'b0, 1'b0, 1'b0};
        vt[7]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0005, 1'b1, 1'b0, 1'b0};
        vt[8]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0005, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0005, 1'b1, 1'b0, 1'b0};
        vt[10] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0005, 1'b0, 1'b0, 1'b0};
        vt[11] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0005, 1'b0, 1'b0, 1'b0};
        vt[12] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0};

        // Reset and free-running scan
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_count", count, 16'h0000);
        chk("rst_running", running, 1'b0);
        chk("rst_expired", expired, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_dig_sel", dig_sel, 4'b0001);
        chk("rst_seg", seg, 7'b1111110);
        check_model();
        for (int k = 0; k < 8; k++) begin
            idle(1'b0);
            chk("scan_sel", dig_sel, scan_exp[k]);
        end

        // Down count with borrow through to expiry
        step(1'b1, 16'h0102, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 249; k++) begin
            idle(1'b1);
            if (k == 4)   chk("down_0101", count, 16'h0101);
            if (k == 8)   chk("down_0100", count, 16'h0100);
            if (k == 12)  chk("down_borrow", count, 16'h0059);
            if (k == 247) chk("down_pre_done", done, 1'b0);
            if (k == 248) begin
                chk("down_zero", count, 16'h0000);
                chk("down_done", done, 1'b1);
                chk("down_expired", expired, 1'b1);
            end
            if (k == 249) begin
                chk("down_done_once", done, 1'b0);
                chk("down_exp_hold", expired, 1'b1);
            end
        end
        step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("exp_ignore_start", expired, 1'b1);
        chk("exp_ignore_run", running, 1'b0);

        // Up count with carry, then saturation at 99:59
        step(1'b1, 16'h0958, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            idle(1'b0);
            if (k == 4) chk("up_0959", count, 16'h0959);
            if (k == 8) chk("up_carry", count, 16'h1000);
        end
        step(1'b1, 16'h9958, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            idle(1'b0);
            if (k == 4) begin
                chk("up_max", count, 16'h9959);
                chk("up_done", done, 1'b1);
            end
            if (k == 12) begin
                chk("up_hold", count, 16'h9959);
                chk("up_expired", expired, 1'b1);
            end
        end

        // Pause with a held prescaler, then resume
        step(1'b1, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 6; k++) idle(1'b1);
        chk("pause_pre", count, 16'h0009);
        step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 20; k++) begin
            idle(1'b1);
            chk("pause_count", count, 16'h0009);
            chk("pause_running", running, 1'b0);
        end
        step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("resume_run", running, 1'b1);
        idle(1'b1);
        chk("resume_1", count, 16'h0009);
        idle(1'b1);
        chk("resume_2", count, 16'h0008);

        // Clamp, priority and immediate-expiry vectors
        for (int i = 0; i < 13; i++) begin
            step(vt[i].l, vt[i].p, vt[i].s, vt[i].sp, vt[i].c, vt[i].d);
            chk("vec_count", count, vt[i].e_cnt);
            chk("vec_running", running, vt[i].e_run);
            chk("vec_expired", expired, vt[i].e_exp);
            chk("vec_done", done, vt[i].e_done);
        end

        // Asynchronous reset in the middle of a run
        step(1'b1, 16'h0043, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 5; k++) idle(1'b1);
        chk("arst_pre", count, 16'h0042);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", count, 16'h0000);
        chk("arst_running", running, 1'b0);
        chk("arst_dig_sel", dig_sel, 4'b0001);
        chk("arst_seg", seg, 7'b1111110);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) idle(1'b0);

        // Random pulses against the model
        for (int n = 0; n < 600; n++) begin
            int          r;
            logic [15:0] p;
            r = $urandom_range(0, 99);
            p = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 65535))
                                             : 16'($urandom_range(0, 16'h0030));
            step(r < 3, p, $urandom_range(0, 9) < 2, $urandom_range(0, 19) == 0,
                 (r >= 3) && (r < 5), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/irrigation_timer_bcd.md
# irrigation_timer_bcd

Parametrised BCD run-time timer for the irrigation controller, replacing the fixed four-digit cascaded seconds/minutes chain. Provides a DIGITS-wide MM:SS / HH:MM:SS counter with preset load, count-up (stopwatch) or count-down (irrigation duration) mode, pause/resume, terminal detection with a done pulse, and an integrated multiplexed 7-segment scan. Sits between the watering-decision logic, which supplies the preset and start/stop pulses, and the display pins.

## Interface
- DIGITS, 4: BCD digit count, even, 2..8. Digit 0 is the least significant.
- PRESCALE, 50000000: clk cycles per one-second tick, ≥2.
- SCAN_DIV, 50000: clk cycles per display digit step, ≥1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  one-cycle pulse; capture preset.
- preset  in  4*DIGITS  BCD preset, digit i at [4i+3:4i].
- start  in  1  one-cycle pulse; run or resume.
- stop  in  1  one-cycle pulse; pause.
- clear  in  1  one-cycle pulse; zero count and go to IDLE.
- dir  in  1  0 = count up, 1 = count down. Sampled when start is accepted from IDLE.
- count  out  4*DIGITS  current BCD value.
- running  out  1  high in RUN.
- expired  out  1  high in EXPIRED.
- done  out  1  one-cycle pulse on entry to EXPIRED.
- seg  out  7  active-high segments, seg[6]=a .. seg[0]=g.
- dig_sel  out  DIGITS  one-hot active-high digit enable.

## Operation
- Digit moduli:
  - Even-index digits count modulo 10.
  - Odd-index digits count modulo 6, except the top digit, which counts modulo 10.
  - DIGITS=4 gives a maximum of 99:59. DIGITS=6 gives a maximum of 99:59:59.
- Load: any preset digit above its modulus-1 is clamped to modulus-1. Load forces IDLE from any state.
- States: IDLE, RUN, PAUSE, EXPIRED. Reset state is IDLE.
- Transitions:
  - IDLE + start → RUN. dir is latched and the prescaler is zeroed.
  - IDLE + start, with latched dir=1 and count=0 → EXPIRED, with a done pulse.
  - PAUSE + start → RUN. The prescaler is not zeroed and dir is not re-latched.
  - RUN + stop → PAUSE. The prescaler value is held.
  - RUN + terminal reached → EXPIRED.
  - EXPIRED: leaves only on clear or load. start and stop are ignored.
  - start while in RUN, or stop outside RUN: ignored.
- Terminal values: down mode is all zeros. Up mode is all digits at max.
- Up-count arithmetic: ripple-carry BCD with per-digit modulus.
- Down-count arithmetic: borrow wraps a digit to modulus-1. Example: 01:00 → 00:59.
- Same-cycle priority: clear > load > stop > start. Lower-priority pulses in that cycle are dropped.
- Display scan:
  - A free-running scan counter advances the digit index every SCAN_DIV cycles, wrapping 0..DIGITS-1.
  - dig_sel has bit index set. seg is the decoded value of that digit, registered together with dig_sel.
  - Digit patterns for 0–9 are standard hex-free decimal. Codes above 9 are unreachable.

## Timing
- Reset values:
  - count=0, running=0, expired=0, done=0.
  - prescaler=0, scan index=0.
  - dig_sel=1 (digit 0), seg=1111110 (digit '0').
- Reset is asynchronous: all state clears on the falling edge of rst_n, including mid-RUN.
- Control pulses take effect at the next rising edge. State and outputs are registered, giving a one-cycle latency.
- Prescaler: increments every RUN cycle. When it equals PRESCALE-1, count updates at that edge and the prescaler returns to 0.
- First count change occurs PRESCALE edges after the edge that entered RUN from IDLE.
- On the edge where count becomes terminal, the following happen together: state=EXPIRED, expired=1, running=0, done=1 for exactly one cycle.
- Scan: dig_sel/seg change every SCAN_DIV cycles, independent of timer state. The scan runs in all states.
- A count change shows on seg no later than the next scan step of that digit.

## Test plan
All scenarios use DIGITS=4, PRESCALE=4, SCAN_DIV=2.
- **Reset:** hold rst_n low, then release. Expect count=0000, running=0, expired=0, done=0, dig_sel=0001, seg=1111110. Over 8 cycles, dig_sel steps 0001→0010→0100→1000→0001, changing every 2 cycles.
- **Down count with borrow:** load 0x0102, dir=1, start.
  - Expect 0101 at start+4 and 0100 at +8.
  - Expect 0059 at +12, showing the borrow.
  - Expect 0000 at +248, with a single-cycle done and expired=1 held.
  - Further start pulses are ignored.
- **Up count with carry and saturation:** load 0x0958, dir=0, start.
  - Expect 0959 at +4 and 1000 at +8.
  - Then load 0x9958 and start. Expect 9959 at +4, expired=1, with no further change.
- **Pause/resume:** load 0x0010, dir=1, start. Pulse stop 6 cycles later, when count=0009 and the prescaler is 2.
  - Hold for 20 cycles: count stays 0009 and running=0.
  - Pulse start: expect 0008 exactly 2 cycles after RUN re-entry.
- **Clamp and priority:**
  - load 0x0A7F gives count 0959.
  - clear and load in the same cycle give 0000 in IDLE.
  - dir=1 and start with count 0000 give EXPIRED plus a done pulse on the next edge.
  - stop and start in the same cycle while in RUN give PAUSE.
- **Async reset mid-run:** during RUN at count 0042, drive rst_n low between clock edges. Expect immediate count=0000, running=0, dig_sel=0001, with no clock edge required.
